apb_mem_slave: RTL and testbench

Synthesizable APB completer that terminates the APB master's bus: a 32-word × 32-bit register memory with byte strobes, programmable wait states, a read-only ID word and privilege-checked protected region. It sits directly downstream of the APB master and drives pready/pslverr/prdata back to it. It replaces the behavioural slave model so the master can be exercised against real wait-state and error timing.

---
 rtl/apb_mem_slave.sv | 122 ++++++++++++
 tb/tb_apb_mem_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer: 32 x 32-bit register memory with byte strobes, programmable
// wait states, a read-only ID word at address 0 and a privileged upper region.
module apb_mem_slave #(
    parameter int          WAIT_CYCLES = 1,
    parameter logic [4:0]  PROT_BASE   = 5'd24,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        clk,
    input  logic        prst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  addr,
    input  logic [2:0]  prot,
    input  logic [3:0]  pstrb,
    input  logic [31:0] pwdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] prdata
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        capture;
    logic        commit;

    logic [4:0]  req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;

    // Word 0 is never written; it exists only to keep the index range simple.
    logic [31:0] mem [32];

    logic done;
    logic err;
    logic unused_prot;

    assign done = (state == ACCESS) && (cnt == 4'd0);
    assign err  = req_write &&
                  ((req_addr == 5'd0) || ((req_addr >= PROT_BASE) && !req_prot[0]));
    assign unused_prot = ^req_prot[2:1];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture    = 1'b1;
                    cnt_next   = 4'(WAIT_CYCLES);
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else if (penable) begin
                    if (cnt != 4'd0) begin
                        cnt_next = cnt - 4'd1;
                    end else begin
                        state_next = IDLE;
                        commit     = req_write && !err;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state is updated only with non-blocking assignments so every
    // register samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (prst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_addr  <= 5'd0;
            req_write <= 1'b0;
            req_wdata <= 32'd0;
            req_strb  <= 4'd0;
            req_prot  <= 3'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (capture) begin
                req_addr  <= addr;
                req_write <= pwrite;
                req_wdata <= pwdata;
                req_strb  <= pstrb;
                req_prot  <= prot;
            end
        end
    end

    // NOTE: the memory is cleared by reset because software expects zeroed
    // registers after reset; this keeps it as flops rather than a RAM macro.
    always_ff @(posedge clk) begin
        if (prst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (req_strb[b]) mem[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
            end
        end
    end

    // Responses depend only on registered state, never on the live bus.
    assign pready  = done;
    assign pslverr = done && err;
    assign prdata  = (done && !req_write)
                   ? ((req_addr == 5'd0) ? ID_VALUE : mem[req_addr])
                   : 32'd0;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench: four slaves with different wait-state settings share one
// bus, each checked against an array-based model of the register map.
module tb_apb_mem_slave;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic        clk = 1'b0;
    logic        prst;
    logic [3:0]  psel_v;
    logic        penable;
    logic        pwrite;
    logic [4:0]  addr;
    logic [2:0]  prot;
    logic [3:0]  pstrb;
    logic [31:0] pwdata;
    logic [3:0]  pready_v;
    logic [3:0]  pslverr_v;
    logic [31:0] prdata_v [4];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int done_cyc;

    logic [31:0] model [4][32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 15;
        apb_mem_slave #(.WAIT_CYCLES(W)) dut (
            .clk     (clk),
            .prst    (prst),
            .psel    (psel_v[g]),
            .penable (penable),
            .pwrite  (pwrite),
            .addr    (addr),
            .prot    (prot),
            .pstrb   (pstrb),
            .pwdata  (pwdata),
            .pready  (pready_v[g]),
            .pslverr (pslverr_v[g]),
            .prdata  (prdata_v[g])
        );
    end

    function automatic int waits_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            2:       return 0;
            default: return 15;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clear_model();
        for (int d = 0; d < 4; d++)
            for (int w = 0; w < 32; w++) model[d][w] = 32'd0;
    endtask

    // One complete transfer; leaves the bus idle-ready so a following call is back-to-back.
    task automatic xfer(input int d, input bit wr, input logic [4:0] a, input logic [2:0] pr,
                        input logic [3:0] st, input logic [31:0] wd, input bit scramble);
        int          k;
        bit          quiet;
        bit          exp_err;
        logic [31:0] exp_rd;
        string       tag;
        tag = $sformatf("d%0d %s a%0d", d, wr ? "wr" : "rd", a);
        psel_v  = 4'(1 << d);
        penable = 1'b0;
        pwrite  = wr;
        addr    = a;
        prot    = pr;
        pstrb   = st;
        pwdata  = wd;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble) begin
            addr   = 5'($urandom);
            pwdata = $urandom;
            pstrb  = 4'($urandom);
            prot   = 3'($urandom);
            pwrite = ~wr;
        end
        k = 0;
        quiet = 1'b1;
        while (!pready_v[d] && k < 40) begin
            if (pslverr_v[d] || prdata_v[d] != 32'd0) quiet = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        check({tag, " latency"}, 32'(k), 32'(waits_of(d)));
        check({tag, " quiet_wait"}, 32'(quiet), 32'd1);
        exp_err = wr && (a == 5'd0 || (a >= 5'd24 && !pr[0]));
        exp_rd  = (a == 5'd0) ? ID : model[d][a];
        check({tag, " pslverr"}, 32'(pslverr_v[d]), 32'(exp_err));
        check({tag, " prdata"}, prdata_v[d], wr ? 32'd0 : exp_rd);
        done_cyc = cyc;
        if (wr && !exp_err)
            for (int b = 0; b < 4; b++)
                if (st[b]) model[d][a][8*b +: 8] = wd[8*b +: 8];
        @(posedge clk); #1;
        check({tag, " pready_1cyc"}, 32'(pready_v[d]), 32'd0);
        psel_v  = 4'd0;
        penable = 1'b0;
    endtask

    initial begin
        int  c0;
        bit  quiet;
        prst = 1'b1; psel_v = 4'd0; penable = 1'b0; pwrite = 1'b0;
        addr = 5'd0; prot = 3'd0; pstrb = 4'd0; pwdata = 32'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check("reset pready", 32'(pready_v), 32'd0);
        check("reset pslverr", 32'(pslverr_v), 32'd0);
        check("reset prdata", prdata_v[0] | prdata_v[1] | prdata_v[2] | prdata_v[3], 32'd0);
        prst = 1'b0;
        @(posedge clk); #1;

        xfer(0, 0, 5'd0,  3'd0, 4'h0, 32'd0, 0);
        xfer(0, 0, 5'd1,  3'd0, 4'h0, 32'd0, 0);
        xfer(0, 0, 5'd31, 3'd0, 4'h0, 32'd0, 0);

        xfer(0, 1, 5'd5, 3'd0, 4'b1111, 32'hDEAD_BEEF, 0);
        xfer(0, 0, 5'd5, 3'd0, 4'h0, 32'd0, 0);
        check("dead_beef", model[0][5], 32'hDEAD_BEEF);
        xfer(0, 1, 5'd5, 3'd0, 4'b0101, 32'h1122_3344, 0);
        xfer(0, 0, 5'd5, 3'd0, 4'h0, 32'd0, 0);
        check("strobe_merge", model[0][5], 32'hDE22_BE44);

        xfer(0, 1, 5'd0,  3'd0, 4'hF, 32'h1234_5678, 0);
        xfer(0, 0, 5'd0,  3'd0, 4'h0, 32'd0, 0);
        xfer(0, 1, 5'd26, 3'b000, 4'hF, 32'hCAFE_F00D, 0);
        xfer(0, 0, 5'd26, 3'b000, 4'h0, 32'd0, 0);
        xfer(0, 1, 5'd26, 3'b001, 4'hF, 32'hCAFE_F00D, 0);
        xfer(0, 0, 5'd26, 3'b000, 4'h0, 32'd0, 0);

        for (int d = 0; d < 4; d++) begin
            xfer(d, 1, 5'd3, 3'd0, 4'hF, 32'd7, 0);
            c0 = done_cyc;
            xfer(d, 0, 5'd3, 3'd0, 4'h0, 32'd0, 0);
            check($sformatf("d%0d back_to_back gap", d), 32'(done_cyc - c0), 32'(waits_of(d) + 2));
        end

        xfer(2, 1, 5'd10, 3'd0, 4'hF, 32'h0BAD_CAFE, 1);
        xfer(2, 0, 5'd10, 3'd0, 4'h0, 32'd0, 0);
        xfer(3, 1, 5'd11, 3'd1, 4'hF, 32'h1357_9BDF, 1);
        xfer(3, 0, 5'd11, 3'd0, 4'h0, 32'd0, 0);

        // Abort on the 3-wait slave: psel drops during a wait state.
        xfer(1, 1, 5'd7, 3'd0, 4'hF, 32'h0000_0055, 0);
        psel_v = 4'b0010; penable = 1'b0; pwrite = 1'b1; addr = 5'd7;
        pstrb = 4'hF; pwdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel_v = 4'd0; penable = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (pready_v[1]) quiet = 1'b0;
            @(posedge clk); #1;
        end
        check("abort no_pready", 32'(quiet), 32'd1);
        xfer(1, 0, 5'd7, 3'd0, 4'h0, 32'd0, 0);

        // Reset in the middle of an access phase.
        psel_v = 4'b0001; penable = 1'b0; pwrite = 1'b1; addr = 5'd9;
        pstrb = 4'hF; pwdata = 32'h9999_9999; prot = 3'd0;
        @(posedge clk); #1;
        penable = 1'b1;
        prst = 1'b1;
        @(posedge clk); #1;
        check("midreset pready", 32'(pready_v), 32'd0);
        check("midreset pslverr", 32'(pslverr_v), 32'd0);
        check("midreset prdata", prdata_v[0], 32'd0);
        prst = 1'b0; psel_v = 4'd0; penable = 1'b0;
        clear_model();
        @(posedge clk); #1;
        xfer(0, 0, 5'd5, 3'd0, 4'h0, 32'd0, 0);
        xfer(0, 0, 5'd9, 3'd0, 4'h0, 32'd0, 0);
        xfer(0, 0, 5'd26, 3'd0, 4'h0, 32'd0, 0);

        for (int i = 0; i < 150; i++) begin
            int          d;
            logic [4:0]  a;
            d = int'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? 5'(24 + $urandom_range(0, 7)) : 5'($urandom);
            xfer(d, 1'($urandom), a, 3'($urandom), 4'($urandom), $urandom, 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
